// File: rtl/l2_arbiter.sv
// Two-port L1 I/D to unified L2 arbiter: one grant at a time, response routed to the owner only.
// Tie policy: round-robin when ARB_ROUND_ROBIN_EN is defined, otherwise fixed D-cache priority.
module l2_arbiter #(
    localparam int unsigned LINE_W = 256,
    localparam int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       i_req, d_req, tie_pick_d;

    // last_grant resets to D so the first round-robin tie goes to the I-cache
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        i_req        = i_read;
        d_req        = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
        tie_pick_d   = ~last_grant_q;
`else
        tie_pick_d   = 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = tie_pick_d ? GRANT_D : GRANT_I;
                end else if (i_req) begin
                    state_d = GRANT_I;
                end else if (d_req) begin
                    state_d = GRANT_D;
                end
            end
            GRANT_I: begin
                if (l2_resp) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            GRANT_D: begin
                if (l2_resp) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pure steering: the owner sees the L2 port, everyone else sees zeros
    always_comb begin
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = '0;
        l2_wdata   = '0;
        i_rdata    = '0;
        i_resp     = 1'b0;
        d_rdata    = '0;
        d_resp     = 1'b0;
        case (state_q)
            GRANT_I: begin
                l2_read    = i_read;
                l2_address = i_address;
                i_rdata    = l2_rdata;
                i_resp     = l2_resp;
            end
            GRANT_D: begin
                l2_write   = d_write;
                l2_read    = d_read & ~d_write;
                l2_address = d_address;
                l2_wdata   = d_wdata;
                d_rdata    = l2_rdata;
                d_resp     = l2_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: vector table, directed corner sequences and a randomized
// run against an owner-tracking reference model. Honours ARB_ROUND_ROBIN_EN like the design.
module tb_l2_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_read = 1'b0;
    logic [31:0]  i_address = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_address = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         l2_read;
    logic         l2_write;
    logic [31:0]  l2_address;
    logic [255:0] l2_wdata;
    logic [255:0] l2_rdata = '0;
    logic         l2_resp = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    l2_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    always #5 clk = ~clk;

    // Reference model: who currently owns the L2 port (0 none, 1 I-cache, 2 D-cache)
    int m_owner = 0;
    bit m_last_d = 1'b1;

    function automatic int tie_winner(input bit last_d);
`ifdef ARB_ROUND_ROBIN_EN
        return last_d ? 1 : 2;
`else
        return 2;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner  <= 0;
            m_last_d <= 1'b1;
        end else if (m_owner == 0) begin
            if (i_read && (d_read || d_write)) m_owner <= tie_winner(m_last_d);
            else if (i_read)                   m_owner <= 1;
            else if (d_read || d_write)        m_owner <= 2;
        end else if (l2_resp) begin
            m_last_d <= (m_owner == 2);
            m_owner  <= 0;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic         e_rd, e_wr, e_ir, e_dr;
        logic [31:0]  e_a;
        logic [255:0] e_wd, e_ird, e_drd;
        e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_a = '0; e_wd = '0; e_ird = '0; e_drd = '0;
        if (m_owner == 1) begin
            e_rd = i_read; e_a = i_address; e_ird = l2_rdata; e_ir = l2_resp;
        end else if (m_owner == 2) begin
            e_wr = d_write; e_rd = d_read && !d_write; e_a = d_address; e_wd = d_wdata;
            e_drd = l2_rdata; e_dr = l2_resp;
        end
        chk({tag, ".l2_read"},    256'(l2_read),    256'(e_rd));
        chk({tag, ".l2_write"},   256'(l2_write),   256'(e_wr));
        chk({tag, ".l2_address"}, 256'(l2_address), 256'(e_a));
        chk({tag, ".l2_wdata"},   l2_wdata,         e_wd);
        chk({tag, ".i_rdata"},    i_rdata,          e_ird);
        chk({tag, ".i_resp"},     256'(i_resp),     256'(e_ir));
        chk({tag, ".d_rdata"},    d_rdata,          e_drd);
        chk({tag, ".d_resp"},     256'(d_resp),     256'(e_dr));
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    endtask

    // Holds reset across two edges and releases it just after an edge; state is IDLE after this
    task automatic do_reset();
        tick();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic       i_rd, d_rd, d_wr, l2r;
        logic [3:0] exp; // {l2_read, l2_write, i_resp, d_resp}
    } vec_t;

    vec_t tbl[17];
    logic [3:0] got;
    logic [255:0] line;
    bit i_done, d_done;
    int win;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b1010};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0100};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b0101};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1000};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0100};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b1001};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b1010};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b1001};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};

        // Reset state: outputs zero even with requests and an L2 response present
        i_read = 1; d_write = 1; l2_resp = 1; l2_rdata = rand256(); d_wdata = rand256();
        i_address = 32'h0000_1040; d_address = 32'h8000_0020;
        #2;
        chk("rst.l2_read",  256'(l2_read),  256'(0));
        chk("rst.l2_write", 256'(l2_write), 256'(0));
        chk("rst.l2_wdata", l2_wdata,       256'(0));
        chk("rst.i_resp",   256'(i_resp),   256'(0));
        chk("rst.d_resp",   256'(d_resp),   256'(0));
        do_reset();

        // Vector table
        foreach (tbl[v]) begin
            tick();
            i_read = tbl[v].i_rd; d_read = tbl[v].d_rd; d_write = tbl[v].d_wr; l2_resp = tbl[v].l2r;
            l2_rdata = rand256(); d_wdata = rand256(); i_address = $urandom; d_address = $urandom;
            #2;
            got = {l2_read, l2_write, i_resp, d_resp};
            chk($sformatf("tbl%0d.ctrl", v), 256'(got), 256'(tbl[v].exp));
            check_model($sformatf("tbl%0d", v));
        end

        // Reset in the middle of a D-cache writeback
        do_reset();
        d_write = 1; d_address = 32'h8000_0040; d_wdata = rand256();
        #2; chk("rstmid.idle_write", 256'(l2_write), 256'(0));
        tick(); #2; chk("rstmid.granted", 256'(l2_write), 256'(1));
        tick(); rst = 0; #2; chk("rstmid.in_rst0", 256'(l2_write), 256'(0));
        tick(); #2; chk("rstmid.in_rst1", 256'(l2_write), 256'(0));
        tick(); rst = 1; #2; chk("rstmid.release", 256'(l2_write), 256'(0));
        tick(); #2; chk("rstmid.regrant", 256'(l2_write), 256'(1));
        chk("rstmid.no_resp", 256'(d_resp), 256'(0));
        tick(); l2_resp = 1; #2; chk("rstmid.d_resp", 256'(d_resp), 256'(1));
        tick(); l2_resp = 0; d_write = 0; #2; chk("rstmid.d_resp_end", 256'(d_resp), 256'(0));

        // Lone I-cache read with a three-cycle L2 latency
        tick(); i_read = 1; i_address = 32'h0000_1040; #2;
        chk("iread.idle", 256'(l2_read), 256'(0));
        tick(); #2;
        chk("iread.l2_read", 256'(l2_read), 256'(1));
        chk("iread.addr", 256'(l2_address), 256'(32'h0000_1040));
        tick(); #2; chk("iread.wait1", 256'(i_resp), 256'(0));
        tick(); #2; chk("iread.wait2", 256'(i_resp), 256'(0));
        tick(); l2_resp = 1; l2_rdata = {8{32'hDEAD_BEEF}}; #2;
        line = {8{32'hDEAD_BEEF}};
        chk("iread.rdata", i_rdata, line);
        chk("iread.i_resp", 256'(i_resp), 256'(1));
        chk("iread.d_resp", 256'(d_resp), 256'(0));
        chk("iread.d_rdata", d_rdata, 256'(0));
        tick(); l2_resp = 0; i_read = 0; #2; chk("iread.done", 256'(i_resp), 256'(0));

        // Both requesters held continuously from reset
        do_reset();
        i_read = 1; d_read = 1; i_address = 32'h0000_2000; d_address = 32'h0000_3000;
        #2; chk("tie.idle0", 256'(l2_read), 256'(0));
        for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = (t % 2 == 0) ? 1 : 2;
`else
            win = 2;
`endif
            tick(); l2_resp = 1; l2_rdata = rand256(); #2;
            chk($sformatf("tie%0d.l2_read", t), 256'(l2_read), 256'(1));
            chk($sformatf("tie%0d.i_resp", t), 256'(i_resp), 256'(win == 1));
            chk($sformatf("tie%0d.d_resp", t), 256'(d_resp), 256'(win == 2));
            tick(); l2_resp = 0; #2;
            chk($sformatf("tie%0d.gap", t), 256'(l2_read), 256'(0));
        end
        clear_inputs();

        // D-cache writeback followed by a read
        tick(); d_write = 1; d_wdata = {8{32'h1234_5678}}; d_address = 32'h8000_0020; #2;
        tick(); #2;
        line = {8{32'h1234_5678}};
        chk("wb.l2_write", 256'(l2_write), 256'(1));
        chk("wb.l2_read", 256'(l2_read), 256'(0));
        chk("wb.l2_wdata", l2_wdata, line);
        chk("wb.l2_address", 256'(l2_address), 256'(32'h8000_0020));
        tick(); l2_resp = 1; #2; chk("wb.d_resp", 256'(d_resp), 256'(1));
        tick(); l2_resp = 0; d_write = 0; d_read = 1; #2; chk("rd.idle", 256'(l2_read), 256'(0));
        tick(); #2;
        chk("rd.l2_read", 256'(l2_read), 256'(1));
        chk("rd.l2_write", 256'(l2_write), 256'(0));
        tick(); l2_resp = 1; l2_rdata = rand256(); #2;
        chk("rd.d_rdata", d_rdata, l2_rdata);
        chk("rd.i_rdata", i_rdata, 256'(0));
        tick(); clear_inputs(); #2;

        // Spurious L2 response while idle, then a request must still be granted next edge
        tick(); l2_resp = 1; #2;
        chk("spur.i_resp", 256'(i_resp), 256'(0));
        chk("spur.d_resp", 256'(d_resp), 256'(0));
        tick(); l2_resp = 0; i_read = 1; #2; chk("spur.idle", 256'(l2_read), 256'(0));
        tick(); #2; chk("spur.grant", 256'(l2_read), 256'(1));
        tick(); l2_resp = 1; #2; chk("spur.i_resp2", 256'(i_resp), 256'(1));
        tick(); clear_inputs();

        // Randomized traffic against the model, with occasional resets
        i_done = 0; d_done = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom % 200 == 0) ? 1'b0 : 1'b1;
            if (i_done) i_read = 0;
            if (d_done) begin d_read = 0; d_write = 0; end
            if (!i_read && ($urandom % 3 == 0)) begin
                i_read = 1; i_address = $urandom;
            end
            if (!d_read && !d_write && ($urandom % 3 == 0)) begin
                d_address = $urandom; d_wdata = rand256();
                case ($urandom % 8)
                    0, 1, 2: d_read = 1;
                    3, 4, 5, 6: d_write = 1;
                    default: begin d_read = 1; d_write = 1; end
                endcase
            end
            l2_resp = ($urandom % 4 == 0);
            l2_rdata = rand256();
            #2;
            check_model($sformatf("rnd%0d", c));
            i_done = rst && (m_owner == 1) && l2_resp;
            d_done = rst && (m_owner == 2) && l2_resp;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
